// File: rtl/adder_pkg.sv
// Shared types and arithmetic helpers for the framed adder tree accumulator.
// Helpers work on MAX_W-bit vectors; callers pass operands already extended.
package adder_pkg;

    localparam int MAX_W = 64;

    typedef enum logic {
        ACCUM = 1'b0,
        IDLE  = 1'b1
    } acc_state_e;

    typedef struct packed {
        logic [MAX_W-1:0] sum;
        logic             ovf;
    } sat_res_t;

    function automatic logic [MAX_W-1:0] width_mask(input int unsigned w);
        return (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
    endfunction

    // Adds two extended operands and checks the result against a w-bit range.
    function automatic sat_res_t sat_add(input logic [MAX_W-1:0] a,
                                         input logic [MAX_W-1:0] b,
                                         input int unsigned      w,
                                         input logic             is_signed,
                                         input logic             saturate);
        logic signed [MAX_W:0] full;
        logic signed [MAX_W:0] hi;
        logic [MAX_W-1:0]      mask;
        sat_res_t              r;
        mask = width_mask(w);
        if (is_signed) begin
            full  = $signed({a[MAX_W-1], a}) + $signed({b[MAX_W-1], b});
            hi    = full >>> (w - 1);
            r.ovf = (hi != '0) && (hi != '1);
        end else begin
            full  = $signed({1'b0, a}) + $signed({1'b0, b});
            hi    = '0;
            r.ovf = ((full >> w) != '0);
        end
        r.sum = full[MAX_W-1:0] & mask;
        if (r.ovf && saturate) begin
            if (!is_signed)
                r.sum = mask;
            else if (full[MAX_W])
                r.sum = (mask >> 1) + MAX_W'(1);
            else
                r.sum = mask >> 1;
        end
        return r;
    endfunction

    function automatic logic [MAX_W-1:0] sat_inc(input logic [MAX_W-1:0] v,
                                                 input int unsigned      w);
        return (v == width_mask(w)) ? v : v + MAX_W'(1);
    endfunction

endpackage

// File: rtl/adder_tree_pipe.sv
// Masked balanced adder tree with valid/last sideband and TREE_DELAY register stages.
// Lanes are padded to a power of two with zeros; levels are grouped per stage.
module adder_tree_pipe
    import adder_pkg::*;
#(
    parameter int  NUM_INPUT  = 8,
    parameter int  WIDTH_IN   = 16,
    parameter int  IS_SIGNED  = 1,
    parameter int  TREE_DELAY = 1,
    localparam int TREE_W     = WIDTH_IN + $clog2(NUM_INPUT)
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_ena,
    input  logic                i_valid,
    input  logic                i_last,
    input  logic [WIDTH_IN-1:0] i_data [NUM_INPUT],
    input  logic [NUM_INPUT-1:0] i_lane_en,
    output logic                o_valid,
    output logic                o_last,
    output logic [TREE_W-1:0]   o_sum
);

    localparam int LEVELS = $clog2(NUM_INPUT);
    localparam int PADDED = 1 << LEVELS;
    localparam int PER    = (TREE_DELAY <= 0 || LEVELS == 0) ? 1 : (LEVELS + TREE_DELAY - 1) / TREE_DELAY;
    localparam int N_REG  = (TREE_DELAY <= 0) ? 0 : (LEVELS + PER - 1) / PER;
    localparam int N_PAD  = (TREE_DELAY > N_REG) ? TREE_DELAY - N_REG : 0;

    if (WIDTH_IN <= 0) begin : g_chk_width
        $error("adder_tree_pipe: WIDTH_IN must be > 0");
    end
    if (TREE_DELAY < 0 || TREE_DELAY > LEVELS) begin : g_chk_delay
        $error("adder_tree_pipe: TREE_DELAY must be within 0..$clog2(NUM_INPUT)");
    end

    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        localparam int CNT = PADDED >> l;
        logic [TREE_W-1:0] sum [CNT];
        logic              vld;
        logic              lst;
        if (l == 0) begin : g_leaf
            for (genvar i = 0; i < CNT; i++) begin : g_lane
                if (i < NUM_INPUT) begin : g_real
                    logic [TREE_W-1:0] ext;
                    if (IS_SIGNED != 0) begin : g_sext
                        assign ext = TREE_W'($signed(i_data[i]));
                    end else begin : g_zext
                        assign ext = TREE_W'(i_data[i]);
                    end
                    assign sum[i] = i_lane_en[i] ? ext : '0;
                end else begin : g_zero
                    assign sum[i] = '0;
                end
            end
            assign vld = i_valid;
            assign lst = i_valid & i_last;
        end else begin : g_node
            logic [TREE_W-1:0] sum_d [CNT];
            always_comb begin
                for (int unsigned i = 0; i < CNT; i++)
                    sum_d[i] = g_lvl[l-1].sum[2*i] + g_lvl[l-1].sum[2*i+1];
            end
            if (TREE_DELAY > 0 && ((l % PER) == 0 || l == LEVELS)) begin : g_reg
                logic [TREE_W-1:0] sum_q [CNT];
                logic              vld_q;
                logic              lst_q;
                always_ff @(posedge i_clk or negedge i_rst_n) begin
                    if (!i_rst_n) begin
                        for (int unsigned i = 0; i < CNT; i++) sum_q[i] <= '0;
                        vld_q <= 1'b0;
                        lst_q <= 1'b0;
                    end else if (i_ena) begin
                        sum_q <= sum_d;
                        vld_q <= g_lvl[l-1].vld;
                        lst_q <= g_lvl[l-1].lst;
                    end
                end
                assign sum = sum_q;
                assign vld = vld_q;
                assign lst = lst_q;
            end else begin : g_comb
                assign sum = sum_d;
                assign vld = g_lvl[l-1].vld;
                assign lst = g_lvl[l-1].lst;
            end
        end
    end

    // When the level grouping yields fewer boundaries than TREE_DELAY, the rest become plain delays.
    for (genvar k = 0; k <= N_PAD; k++) begin : g_dly
        logic [TREE_W-1:0] sum;
        logic              vld;
        logic              lst;
        if (k == 0) begin : g_src
            assign sum = g_lvl[LEVELS].sum[0];
            assign vld = g_lvl[LEVELS].vld;
            assign lst = g_lvl[LEVELS].lst;
        end else begin : g_stage
            logic [TREE_W-1:0] sum_q;
            logic              vld_q;
            logic              lst_q;
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    sum_q <= '0;
                    vld_q <= 1'b0;
                    lst_q <= 1'b0;
                end else if (i_ena) begin
                    sum_q <= g_dly[k-1].sum;
                    vld_q <= g_dly[k-1].vld;
                    lst_q <= g_dly[k-1].lst;
                end
            end
            assign sum = sum_q;
            assign vld = vld_q;
            assign lst = lst_q;
        end
    end

    assign o_sum   = g_dly[N_PAD].sum;
    assign o_valid = g_dly[N_PAD].vld;
    assign o_last  = g_dly[N_PAD].lst;

endmodule

// File: rtl/adder_tree_accum.sv
// Framed accumulator on top of the masked adder tree: sums beats until a last
// beat, then emits the frame total, sticky overflow and beat count for one cycle.
module adder_tree_accum
    import adder_pkg::*;
#(
    parameter int  NUM_INPUT  = 8,
    parameter int  WIDTH_IN   = 16,
    parameter int  IS_SIGNED  = 1,
    parameter int  TREE_DELAY = 1,
    parameter int  ACC_EXTRA  = 8,
    parameter int  SATURATE   = 1,
    parameter int  COUNT_W    = 8,
    localparam int TREE_W     = WIDTH_IN + $clog2(NUM_INPUT),
    localparam int WIDTH_OUT  = TREE_W + ACC_EXTRA
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_ena,
    input  logic                 i_valid,
    input  logic                 i_last,
    input  logic [WIDTH_IN-1:0]  i_data [NUM_INPUT],
    input  logic [NUM_INPUT-1:0] i_lane_en,
    output logic                 o_valid,
    output logic [WIDTH_OUT-1:0] o_data,
    output logic                 o_overflow,
    output logic [COUNT_W-1:0]   o_count
);

    if (NUM_INPUT < 1) begin : g_chk_lanes
        $error("adder_tree_accum: NUM_INPUT must be >= 1");
    end
    if (WIDTH_OUT >= MAX_W || COUNT_W >= MAX_W) begin : g_chk_wide
        $error("adder_tree_accum: WIDTH_OUT and COUNT_W must be below adder_pkg::MAX_W");
    end

    logic                 t_valid;
    logic                 t_last;
    logic [TREE_W-1:0]    t_sum;

    acc_state_e           state_q, state_d;
    logic [WIDTH_OUT-1:0] acc_q, acc_d;
    logic                 ovf_q, ovf_d;
    logic [COUNT_W-1:0]   cnt_q, cnt_d;
    logic                 o_valid_q, o_valid_d;
    logic [WIDTH_OUT-1:0] o_data_q, o_data_d;
    logic                 o_ovf_q, o_ovf_d;
    logic [COUNT_W-1:0]   o_count_q, o_count_d;

    logic [MAX_W-1:0]     acc_ext;
    logic [MAX_W-1:0]     beat_ext;
    sat_res_t             res;

    adder_tree_pipe #(
        .NUM_INPUT  (NUM_INPUT),
        .WIDTH_IN   (WIDTH_IN),
        .IS_SIGNED  (IS_SIGNED),
        .TREE_DELAY (TREE_DELAY)
    ) u_tree (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_ena     (i_ena),
        .i_valid   (i_valid),
        .i_last    (i_last),
        .i_data    (i_data),
        .i_lane_en (i_lane_en),
        .o_valid   (t_valid),
        .o_last    (t_last),
        .o_sum     (t_sum)
    );

    always_comb begin
        if (IS_SIGNED != 0) begin
            acc_ext  = MAX_W'($signed(acc_q));
            beat_ext = MAX_W'($signed(t_sum));
        end else begin
            acc_ext  = MAX_W'(acc_q);
            beat_ext = MAX_W'(t_sum);
        end
        if (state_q == IDLE) acc_ext = '0;
        res = sat_add(acc_ext, beat_ext, WIDTH_OUT, IS_SIGNED != 0, SATURATE != 0);
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        cnt_d     = cnt_q;
        o_valid_d = 1'b0;
        o_data_d  = o_data_q;
        o_ovf_d   = o_ovf_q;
        o_count_d = o_count_q;
        if (t_valid) begin
            acc_d   = WIDTH_OUT'(res.sum);
            ovf_d   = res.ovf | ((state_q == ACCUM) & ovf_q);
            cnt_d   = (state_q == IDLE) ? COUNT_W'(1) : COUNT_W'(sat_inc(MAX_W'(cnt_q), COUNT_W));
            state_d = t_last ? IDLE : ACCUM;
            if (t_last) begin
                o_valid_d = 1'b1;
                o_data_d  = acc_d;
                o_ovf_d   = ovf_d;
                o_count_d = cnt_d;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            cnt_q     <= '0;
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
            o_ovf_q   <= 1'b0;
            o_count_q <= '0;
        end else if (i_ena) begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
            cnt_q     <= cnt_d;
            o_valid_q <= o_valid_d;
            o_data_q  <= o_data_d;
            o_ovf_q   <= o_ovf_d;
            o_count_q <= o_count_d;
        end
    end

    assign o_valid    = o_valid_q;
    assign o_data     = o_data_q;
    assign o_overflow = o_ovf_q;
    assign o_count    = o_count_q;

endmodule

// File: doc/adder_tree_accum.md
# adder_tree_accum

Streaming, pipelined, balanced adder tree with per-lane masking, valid/last sideband and a frame accumulator. Each valid beat sums the enabled lanes of `i_data`. Beat sums are accumulated until a beat marked `i_last`, and the frame total is then emitted with a one-cycle `o_valid`. It is the successor of the unframed masked adder tree, used by channel-combining and integrate-and-dump datapaths.

## Interface
- `NUM_INPUT`, 8: number of input lanes (≥1, any count, odd allowed).
- `WIDTH_IN`, 16: bits per lane (>0).
- `IS_SIGNED`, 1: 1 = two's complement, 0 = unsigned.
- `TREE_DELAY`, 1: register stages inside the tree, 0..$clog2(NUM_INPUT). Levels are grouped as in the existing tree, ceil(levels/TREE_DELAY) per stage.
- `ACC_EXTRA`, 8: guard bits added for accumulation.
- `SATURATE`, 1: 1 = clamp the accumulator on overflow, 0 = wrap.
- `COUNT_W`, 8: width of the beat counter.
- `TREE_W` (derived), `WIDTH_IN + $clog2(NUM_INPUT)`.
- `WIDTH_OUT` (derived), `TREE_W + ACC_EXTRA`.

Ports:
- `i_clk` in 1: the single clock.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_ena` in 1: clock enable. When low, every register holds, including valid and the outputs.
- `i_valid` in 1: the beat is present.
- `i_last` in 1: final beat of the frame. Qualified by `i_valid`.
- `i_data` in `[WIDTH_IN-1:0] x NUM_INPUT`: lane data (unpacked array).
- `i_lane_en` in NUM_INPUT: per-lane participation mask. 0 = lane treated as 0.
- `o_valid` out 1: frame result strobe.
- `o_data` out WIDTH_OUT: frame total.
- `o_overflow` out 1: the frame hit overflow at least once.
- `o_count` out COUNT_W: valid beats in the frame, saturating at `2^COUNT_W-1`.

## Operation
- **Lane extension:** enabled lanes are sign-extended (`IS_SIGNED`=1) or zero-extended to TREE_W. Disabled lanes are all-zero across the full TREE_W. Tree sums are exact (no overflow possible).
- **Sideband pipeline:** `valid` and `last` travel with the data through each tree register stage. The lane mask is applied at stage 0 only.
- **Accumulator state:** `first` flag. Reset value 1 = IDLE (next beat starts a frame); 0 = ACCUM.
- **Accumulate step,** on a tree-output beat with valid=1: `sum = (first ? 0 : acc) + sext/zext(tree_sum)`, computed at WIDTH_OUT+1 bits.
  - Overflow: out of WIDTH_OUT range; signed or unsigned per `IS_SIGNED`.
  - With overflow and `SATURATE`=1: clamp to max/min. With `SATURATE`=0: truncate.
  - Overflow sets the frame-sticky `ovf`.
  - `cnt = first ? 1 : sat_inc(cnt)`.
- **Transitions:** valid & !last gives ACCUM (`first`←0). Valid & last gives IDLE (`first`←1).
- **Frame result:** on a valid & last beat, `o_data`←sum, `o_overflow`←`ovf` of the frame including this beat, `o_count`←`cnt`, `o_valid`←1.
- **Between frames:** `o_valid`←0. `o_data`, `o_overflow` and `o_count` hold their last frame values.
- **Beat handling:**
  - Beats with `i_valid`=0 are ignored: no accumulation, no count. Gaps inside a frame are allowed.
  - `i_last` with `i_valid`=0 is ignored.
  - A single beat with `i_last`=1 is a one-beat frame. Output = masked lane sum, `o_count`=1.
- **Reset (asynchronous, any time including mid-frame):**
  - Clears all tree stage registers, the sideband pipeline and `acc`.
  - `ovf`=0, `cnt`=0, `first`=1.
  - Outputs: `o_valid`=0, `o_data`=0, `o_overflow`=0, `o_count`=0.
  - A partial frame is discarded, not emitted.
- **`i_ena`=0:** full freeze. A registered `o_valid`=1 stays high while frozen; consumers qualify with `i_ena`.

## Timing
- **Latency:** TREE_DELAY+1 enabled cycles from the `i_last` beat to `o_valid`.
- **Throughput:** one beat per enabled cycle, no backpressure.
- **Frame pipelining:** back-to-back frames are legal. The beat after a last beat starts a new frame in the very next cycle, with no bubble. Consecutive `o_valid` pulses are possible (all one-beat frames).
- **`TREE_DELAY`=0:** the tree is combinational and latency is 1.
- **`NUM_INPUT`=1:** the tree degenerates to a wire (levels=0). `TREE_DELAY` must be 0; any other value is flagged by an elaboration `$error`.
- **Parameter checks:** `TREE_DELAY` > levels, or `WIDTH_IN` ≤ 0, also give `$error`.

## Structure
- **Package `adder_pkg`:**
  - `acc_state_e` {IDLE, ACCUM}.
  - Function `sat_add(a, b, is_signed, saturate)` returning {sum, ovf}.
  - Function `sat_inc` for the counter.
- **Sub-module `adder_tree_pipe`:** masked, balanced tree with `valid`/`last` sideband and `TREE_DELAY` staging, async active-low reset. Reused standalone elsewhere.
- **Top:** instantiates `adder_tree_pipe` and holds the accumulator, counter, flags and output registers.

## Test plan
- **Single beat:** NUM_INPUT=8, W=16, signed, TREE_DELAY=1. One beat, lanes 1..8, mask 0xFF, last=1 → after 2 cycles `o_valid`=1, `o_data`=36, `o_count`=1, `o_overflow`=0.
- **Masking with gap:** mask 0x0F, lanes all −3, 4-beat frame with one `i_valid`=0 gap mid-frame → `o_data`=−48, `o_count`=4.
- **Saturation:** unsigned, W=8, ACC_EXTRA=0, all lanes 255, 2-beat frame → `o_data`=2047 (clamped), `o_overflow`=1. Next frame of one beat with lanes 0 → `o_data`=0, `o_overflow`=0.
- **Back-to-back frames:** last=1 on every beat, data k per lane on beat k → consecutive `o_valid` pulses, `o_data`=8k each, no gaps.
- **Reset and freeze:** assert `i_rst_n`=0 mid-frame after 3 beats → outputs 0 immediately (async). Next 2-beat frame reports only its own sum, `o_count`=2. Hold `i_ena`=0 for 5 cycles mid-pipeline → result and latency shift by exactly 5 cycles.
- **Odd lane count:** NUM_INPUT=5, TREE_DELAY=3, lanes 1..5 → `o_data`=15 after 4 cycles.
